// File: rtl/fnd_decoder_if.sv
// Multiplexed 4-digit 7-segment bus snooped by fnd_decoder.
// The scan driver owns the master side; the decoder only observes.
interface fnd_decoder_if;
  logic [3:0] fnd_com;
  logic [7:0] fnd_data;

  modport master (output fnd_com, output fnd_data);
  modport slave  (input  fnd_com, input  fnd_data);
endinterface

// File: rtl/fnd_decoder.sv
// Rebuilds 4-digit frames from a scanned 7-segment bus and reports them as BCD and binary.
// Optional hex digits A..d are enabled by defining FND_DECODER_HEX_EN.
module fnd_decoder #(
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic               clk,
  input  logic               reset_n,
  fnd_decoder_if.slave       bus,
  output logic [15:0]        o_digits,
  output logic [7:0]         o_lo_bin,
  output logic [7:0]         o_hi_bin,
  output logic               o_dot,
  output logic               o_frame_valid,
  output logic               o_err,
  output logic               o_stale
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYC);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {SEG_DIGIT, SEG_BLANK, SEG_DOT, SEG_BAD} seg_kind_e;
  typedef struct packed {
    seg_kind_e  kind;
    logic [3:0] val;
  } seg_dec_t;

  function automatic seg_dec_t decode_seg(input logic [7:0] seg);
    seg_dec_t r;
    r.kind = SEG_DIGIT;
    r.val  = 4'd0;
    case (seg)
      8'hC0: r.val = 4'd0;
      8'hF9: r.val = 4'd1;
      8'hA4: r.val = 4'd2;
      8'hB0: r.val = 4'd3;
      8'h99: r.val = 4'd4;
      8'h92: r.val = 4'd5;
      8'h82: r.val = 4'd6;
      8'hF8: r.val = 4'd7;
      8'h80: r.val = 4'd8;
      8'h90: r.val = 4'd9;
`ifdef FND_DECODER_HEX_EN
      8'h88: r.val = 4'hA;
      8'h83: r.val = 4'hB;
      8'hC6: r.val = 4'hC;
      8'hA1: r.val = 4'hD;
`endif
      8'hFF: r.kind = SEG_BLANK;
      8'h7F: r.kind = SEG_DOT;
      default: r.kind = SEG_BAD;
    endcase
    return r;
  endfunction

  // Returns {valid, pos}; anything other than a single low bit is not a digit slot.
  function automatic logic [2:0] decode_pos(input logic [3:0] com);
    case (com)
      4'b1110: return {1'b1, 2'd0};
      4'b1101: return {1'b1, 2'd1};
      4'b1011: return {1'b1, 2'd2};
      4'b0111: return {1'b1, 2'd3};
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] mul10_add(input logic [3:0] tens, input logic [3:0] ones);
    return {1'b0, tens, 3'b000} + {3'b000, tens, 1'b0} + {4'b0000, ones};
  endfunction

  logic [11:0]   sync1_q, sync2_q, prev_q;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] to_q, to_d;
  logic [15:0]   dig_q, dig_d;
  logic [3:0]    seen_q, seen_d;
  logic          dot_pend_q, dot_pend_d;
  logic          err_pend_q, err_pend_d;
  logic [15:0]   digits_q, digits_d;
  logic [7:0]    lo_q, lo_d, hi_q, hi_d;
  logic          dot_q, dot_d, fv_q, fv_d, err_q, err_d, stale_q, stale_d;

  logic          stable_s, accept_s, pos_valid_s, frame_s;
  logic [1:0]    pos_s;
  seg_dec_t      dec_s;

  // Settle filter, slot decode, frame assembly and timeout next-state logic.
  always_comb begin
    stable_s    = (sync2_q == prev_q);
    accept_s    = stable_s && (settle_q == SETTLE_LAST);
    {pos_valid_s, pos_s} = decode_pos(sync2_q[11:8]);
    dec_s       = decode_seg(sync2_q[7:0]);

    settle_d    = settle_q;
    dig_d       = dig_q;
    seen_d      = seen_q;
    dot_pend_d  = dot_pend_q;
    err_pend_d  = err_pend_q;
    to_d        = to_q;
    digits_d    = digits_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    dot_d       = dot_q;
    err_d       = err_q;
    stale_d     = stale_q;
    fv_d        = 1'b0;
    frame_s     = 1'b0;

    if (!stable_s) begin
      settle_d = {SW{1'b0}};
    end else if (settle_q != SETTLE_MAX) begin
      settle_d = settle_q + SW'(1);
    end else begin
      settle_d = settle_q;
    end

    if (accept_s && pos_valid_s) begin
      case (dec_s.kind)
        SEG_DIGIT: begin
          dig_d[{pos_s, 2'b00} +: 4] = dec_s.val;
          seen_d[pos_s]              = 1'b1;
        end
        SEG_DOT: begin
          if (pos_s == 2'd2) begin
            dot_pend_d = 1'b1;
          end else begin
            dot_pend_d = dot_pend_q;
          end
        end
        SEG_BAD:   err_pend_d = 1'b1;
        SEG_BLANK: dot_pend_d = dot_pend_q;
        default:   err_pend_d = 1'b1;
      endcase
      frame_s = (dec_s.kind == SEG_DIGIT) && (seen_d == 4'hF);
    end else begin
      frame_s = 1'b0;
    end

    // The completing write itself is folded into the published frame.
    if (frame_s) begin
      digits_d   = dig_d;
      lo_d       = mul10_add(dig_d[7:4], dig_d[3:0]);
      hi_d       = mul10_add(dig_d[15:12], dig_d[11:8]);
      dot_d      = dot_pend_d;
      err_d      = err_pend_d;
      fv_d       = 1'b1;
      stale_d    = 1'b0;
      seen_d     = 4'h0;
      dot_pend_d = 1'b0;
      err_pend_d = 1'b0;
      to_d       = {TW{1'b0}};
    end else if (to_q == TO_LAST) begin
      stale_d    = 1'b1;
    end else begin
      to_d       = to_q + TW'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 12'h000;
      sync2_q    <= 12'h000;
      prev_q     <= 12'h000;
      settle_q   <= {SW{1'b0}};
      to_q       <= {TW{1'b0}};
      dig_q      <= 16'h0000;
      seen_q     <= 4'h0;
      dot_pend_q <= 1'b0;
      err_pend_q <= 1'b0;
      digits_q   <= 16'h0000;
      lo_q       <= 8'h00;
      hi_q       <= 8'h00;
      dot_q      <= 1'b0;
      fv_q       <= 1'b0;
      err_q      <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      sync1_q    <= {bus.fnd_com, bus.fnd_data};
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      settle_q   <= settle_d;
      to_q       <= to_d;
      dig_q      <= dig_d;
      seen_q     <= seen_d;
      dot_pend_q <= dot_pend_d;
      err_pend_q <= err_pend_d;
      digits_q   <= digits_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      dot_q      <= dot_d;
      fv_q       <= fv_d;
      err_q      <= err_d;
      stale_q    <= stale_d;
    end
  end

  assign o_digits      = digits_q;
  assign o_lo_bin      = lo_q;
  assign o_hi_bin      = hi_q;
  assign o_dot         = dot_q;
  assign o_frame_valid = fv_q;
  assign o_err         = err_q;
  assign o_stale       = stale_q;

endmodule
